// File: rtl/reg_dump_sequencer_if.sv
// Debug dump bus: control/status, register-bank debug port and the byte stream to the transmitter.
interface reg_dump_sequencer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
);
  logic               i_start;
  logic               i_abort;
  logic               o_br_enable;
  logic [NB_REG-1:0]  o_br_addr;
  logic [NB_DATA-1:0] i_reg_data;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_start, i_abort, i_reg_data, i_tx_ready,
    input  o_br_enable, o_br_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_reg_data, i_tx_ready,
    output o_br_enable, o_br_addr, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Walks the register bank debug port and streams each word MSB-byte first over valid/ready.
// 6 cycles per register at full rate; a stalled byte holds data, index and byte count until accepted.
module reg_dump_sequencer #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int N_REGS  = 32,
  parameter int NB_BYTE = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  reg_dump_sequencer_if.slave   bus
);
  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [NB_REG-1:0] LAST_IDX  = NB_REG'(N_REGS - 1);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(N_BYTES - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SELECT  = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]         state;
  logic [NB_REG-1:0]  index;
  logic [NB_CNT-1:0]  byte_cnt;
  logic [NB_DATA-1:0] word;
  logic [NB_DATA-1:0] word_sh;
  logic               xfer;

  assign xfer    = (state == ST_SEND) && bus.i_tx_ready;
  assign word_sh = word << (NB_BYTE * byte_cnt);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ST_IDLE;
      index    <= '0;
      byte_cnt <= '0;
      word     <= '0;
    end else if (bus.i_abort) begin
      // Abort wins over start in IDLE and over a concurrent transfer elsewhere.
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.i_start) begin
            state    <= ST_SELECT;
            index    <= '0;
            byte_cnt <= '0;
          end
        end
        ST_SELECT:  state <= ST_CAPTURE;
        ST_CAPTURE: begin
          word  <= bus.i_reg_data;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer) begin
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              // Terminal compare before incrementing keeps index from wrapping.
              if (index == LAST_IDX) begin
                state <= ST_DONE;
              end else begin
                index <= index + 1'b1;
                state <= ST_SELECT;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_br_enable = (state == ST_SELECT) || (state == ST_CAPTURE) || (state == ST_SEND);
  assign bus.o_br_addr   = index;
  assign bus.o_tx_valid  = (state == ST_SEND);
  assign bus.o_tx_data   = (state == ST_SEND) ? word_sh[NB_DATA-1 -: NB_BYTE] : '0;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_done      = (state == ST_DONE);
endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench: expected byte stream is queued per dump request and checked by an independent monitor.
module tb_reg_dump_sequencer;
  localparam int NB_DATA = 32;
  localparam int NB_REG  = 5;
  localparam int N_REGS  = 32;
  localparam int NB_BYTE = 8;
  localparam int NBY     = NB_DATA / NB_BYTE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_dump_sequencer_if #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) bus ();

  reg_dump_sequencer #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .N_REGS(N_REGS), .NB_BYTE(NB_BYTE)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [NB_REG-1:0]  addr;
    logic [NB_BYTE-1:0] dat;
  } exp_t;

  exp_t               exp_q[$];
  exp_t               mon_e;
  logic [NB_DATA-1:0] bank [N_REGS];
  int                 tests    = 0;
  int                 fails    = 0;
  int                 done_cnt = 0;
  int                 rdy_mode = 0;
  logic               prev_hold = 1'b0;
  logic [NB_BYTE-1:0] prev_dat  = '0;

  // Registered bank read: data follows the address one edge later.
  always @(posedge clk) bus.i_reg_data <= bank[bus.o_br_addr];

  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.i_tx_ready = 1'b1;
      1:       bus.i_tx_ready = ~bus.i_tx_ready;
      default: bus.i_tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Monitor samples late in the low phase, i.e. what the next rising edge will commit.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold && bus.o_tx_valid)
          chk("hold_data", 32'(bus.o_tx_data), 32'(prev_dat));
        if (bus.o_tx_valid && bus.i_tx_ready && !bus.i_abort) begin
          if (exp_q.size() == 0) begin
            fail_now("extra_byte");
          end else begin
            mon_e = exp_q.pop_front();
            chk("tx_byte", 32'(bus.o_tx_data), 32'(mon_e.dat));
            chk("tx_addr", 32'(bus.o_br_addr), 32'(mon_e.addr));
          end
        end
        if (bus.o_done) begin
          done_cnt++;
          chk("done_q_empty", 32'(exp_q.size()), 32'd0);
        end
        prev_hold = bus.o_tx_valid && !bus.i_tx_ready && !bus.i_abort;
        prev_dat  = bus.o_tx_data;
      end
    end
  end

  task automatic load_bank(input int kind);
    for (int n = 0; n < N_REGS; n++)
      bank[n] = (kind == 0) ? (32'hA500_0000 + 32'(n << 4) + 32'(n)) : $urandom;
  endtask

  task automatic push_exp();
    exp_t e;
    logic [NB_DATA-1:0] w;
    for (int n = 0; n < N_REGS; n++) begin
      w = bank[n];
      for (int b = NBY - 1; b >= 0; b--) begin
        e.addr = NB_REG'(n);
        e.dat  = w[b*NB_BYTE +: NB_BYTE];
        exp_q.push_back(e);
      end
    end
  endtask

  // Returns one time unit after the edge that accepted the start.
  task automatic pulse_start();
    @(negedge clk);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic run_dump(input int mode, input bit noise, input bit check_time);
    int  c;
    int  d0;
    int  first_v;
    bit  seen;
    d0       = done_cnt;
    rdy_mode = mode;
    push_exp();
    pulse_start();
    chk("busy_after_start", 32'(bus.o_busy), 32'd1);
    chk("addr_at_start", 32'(bus.o_br_addr), 32'd0);
    seen    = 1'b0;
    first_v = -1;
    c       = 0;
    while (!seen && c < 3000) begin
      @(posedge clk);
      #1;
      c++;
      if (first_v < 0 && bus.o_tx_valid) first_v = c;
      if (bus.o_done) seen = 1'b1;
      else if (noise) bus.i_start = ($urandom_range(0, 3) == 0);
    end
    bus.i_start = 1'b0;
    if (!seen) fail_now("done_timeout");
    if (check_time) begin
      chk("first_valid_edge", 32'(first_v), 32'd2);
      chk("done_edge", 32'(c), 32'(6 * N_REGS));
    end
    @(posedge clk);
    #1;
    chk("busy_after_done", 32'(bus.o_busy), 32'd0);
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int c;
    int d0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_tx_ready = 1'b1;
    load_bank(0);

    // Reset held: outputs stay zero whatever start does.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_start = 1'(i % 2);
      @(posedge clk);
      #1;
      chk("reset_outputs", 32'({bus.o_br_enable, bus.o_br_addr, bus.o_tx_data,
                                bus.o_tx_valid, bus.o_busy, bus.o_done}), 32'd0);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", 32'(bus.o_busy), 32'd0);

    load_bank(0);
    run_dump(0, 1'b0, 1'b1);

    load_bank(1);
    bank[0] = 32'h1234_5678;
    run_dump(1, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      load_bank(1);
      run_dump(2, 1'b1, 1'b0);
    end

    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    @(posedge clk);
    #1;
    chk("start_abort_idle_busy", 32'(bus.o_busy), 32'd0);
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    @(posedge clk);
    #1;
    chk("start_abort_idle_valid", 32'(bus.o_tx_valid), 32'd0);

    // Abort on the third byte of register 5 (22 bytes already accepted).
    load_bank(0);
    rdy_mode = 0;
    d0 = done_cnt;
    push_exp();
    pulse_start();
    c = 0;
    while (c < 400 && !(exp_q.size() == N_REGS * NBY - 22 && bus.o_tx_valid)) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) fail_now("abort_wait");
    bus.i_abort = 1'b1;
    #1;
    chk("abort_addr", 32'(bus.o_br_addr), 32'd5);
    @(posedge clk);
    #1;
    bus.i_abort = 1'b0;
    chk("abort_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("abort_enable", 32'(bus.o_br_enable), 32'd0);
    chk("abort_busy", 32'(bus.o_busy), 32'd0);
    chk("abort_done", 32'(bus.o_done), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_dump(0, 1'b0, 1'b1);

    // Asynchronous reset dropped between edges while register 10 is being sent.
    load_bank(1);
    rdy_mode = 0;
    push_exp();
    pulse_start();
    c = 0;
    while (c < 400 && !(bus.o_br_addr == NB_REG'(10) && bus.o_tx_valid)) begin
      @(negedge clk);
      c++;
    end
    if (c >= 400) fail_now("reset_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.o_tx_valid), 32'd0);
    chk("arst_enable", 32'(bus.o_br_enable), 32'd0);
    chk("arst_busy", 32'(bus.o_busy), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("arst_stays_idle", 32'({bus.o_busy, bus.o_tx_valid, bus.o_done}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
